// File: rtl/coverage_tracker_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | coverage_tracker_if : fault-result and status bundle of the      |
// | coverage tracker.                              Rev 1.0           |
// +------------------------------------------------------------------+
interface coverage_tracker_if;
    logic       tv_start;
    logic       fault_valid;
    logic [8:0] fault_idx;
    logic       fault_det;
    logic       tv_done;
    logic       fault_skip;
    logic       busy;
    logic       result_valid;
    logic       keep;
    logic [8:0] ct_count;
    logic [8:0] at_count;
    logic [6:0] coverage_pct;
    logic [5:0] useless_cnt;
    logic       finished;

    modport master (
        output tv_start, fault_valid, fault_idx, fault_det, tv_done,
        input  fault_skip, busy, result_valid, keep, ct_count, at_count,
               coverage_pct, useless_cnt, finished
    );

    modport slave (
        input  tv_start, fault_valid, fault_idx, fault_det, tv_done,
        output fault_skip, busy, result_valid, keep, ct_count, at_count,
               coverage_pct, useless_cnt, finished
    );
endinterface
`default_nettype wire

// File: rtl/coverage_tracker.sv
`default_nettype none
// +------------------------------------------------------------------+
// | coverage_tracker : per-test new-fault counting, accept/reject    |
// | decision, fault dropping and coverage percentage.  Rev 1.0       |
// +------------------------------------------------------------------+
module coverage_tracker #(
    parameter int NUM_FAULTS  = 307,
    parameter int EF_COUNT    = 1,
    parameter int UT_LIMIT    = 50,
    parameter int DESIRED_COV = 95
) (
    input  logic              clk,
    input  logic              reset,
    coverage_tracker_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        MERGE   = 3'd2,
        DIVIDE  = 3'd3,
        REPORT  = 3'd4
    } state_t;

    localparam logic [8:0]  c_num_faults  = 9'(NUM_FAULTS);
    localparam logic [8:0]  c_ef_count    = 9'(EF_COUNT);
    localparam logic [5:0]  c_ut_limit    = 6'(UT_LIMIT);
    localparam logic [16:0] c_target      = 17'(DESIRED_COV * NUM_FAULTS);
    localparam logic [15:0] c_divisor_top = 16'(NUM_FAULTS * 64);

    state_t        r_state;
    state_t        w_next_state;
    logic [NUM_FAULTS:0] r_at_map;
    logic [NUM_FAULTS:0] r_ct_map;
    logic [8:0]    r_ct_count;
    logic [8:0]    r_at_count;
    logic          r_keep;
    logic [6:0]    r_cov;
    logic [5:0]    r_useless;
    logic          r_finished;
    logic [15:0]   r_rem;
    logic [15:0]   r_dvs;
    logic [6:0]    r_quo;
    logic [2:0]    r_step;

    logic          w_in_range;
    logic          w_new_fault;
    logic          w_merge_ok;
    logic [8:0]    w_at_upd;
    logic          w_ge;
    logic          w_cov_hit;

    assign w_in_range  = (bus.fault_idx != 9'd0) && (bus.fault_idx <= c_num_faults);
    assign w_new_fault = bus.fault_valid && bus.fault_det && w_in_range &&
                         !r_at_map[bus.fault_idx] && !r_ct_map[bus.fault_idx];
    assign w_merge_ok  = (r_ct_count >= c_ef_count);
    assign w_at_upd    = w_merge_ok ? (r_at_count + r_ct_count) : r_at_count;
    assign w_ge        = (r_rem >= r_dvs);
    assign w_cov_hit   = ({8'd0, r_at_count} * 17'd100) >= c_target;

    assign bus.fault_skip   = w_in_range && r_at_map[bus.fault_idx];
    assign bus.busy         = (r_state == MERGE) || (r_state == DIVIDE) || (r_state == REPORT);
    assign bus.result_valid = (r_state == REPORT);
    assign bus.keep         = r_keep;
    assign bus.ct_count     = r_ct_count;
    assign bus.at_count     = r_at_count;
    assign bus.coverage_pct = r_cov;
    assign bus.useless_cnt  = r_useless;
    assign bus.finished     = r_finished;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (bus.tv_start && !r_finished) w_next_state = COLLECT;
            COLLECT: if (bus.tv_done) w_next_state = MERGE;
            MERGE:   w_next_state = DIVIDE;
            DIVIDE:  if (r_step == 3'd6) w_next_state = REPORT;
            REPORT:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_at_map   <= '0;
            r_ct_map   <= '0;
            r_ct_count <= '0;
            r_at_count <= '0;
            r_keep     <= 1'b0;
            r_cov      <= '0;
            r_useless  <= '0;
            r_finished <= 1'b0;
            r_rem      <= '0;
            r_dvs      <= '0;
            r_quo      <= '0;
            r_step     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.tv_start && !r_finished) begin
                        r_ct_map   <= '0;
                        r_ct_count <= '0;
                    end
                end
                COLLECT: begin
                    // tv_done outranks a simultaneous restart, so the last fault still counts
                    if (bus.tv_start && !bus.tv_done) begin
                        r_ct_map   <= '0;
                        r_ct_count <= '0;
                    end else if (w_new_fault) begin
                        r_ct_map[bus.fault_idx] <= 1'b1;
                        r_ct_count              <= r_ct_count + 9'd1;
                    end
                end
                MERGE: begin
                    if (w_merge_ok) begin
                        r_at_map   <= r_at_map | r_ct_map;
                        r_at_count <= w_at_upd;
                        r_keep     <= 1'b1;
                        r_useless  <= '0;
                    end else begin
                        r_keep <= 1'b0;
                        if (r_useless != 6'd63) r_useless <= r_useless + 6'd1;
                    end
                    r_rem  <= 16'(w_at_upd) * 16'd100;
                    r_dvs  <= c_divisor_top;
                    r_quo  <= '0;
                    r_step <= '0;
                end
                DIVIDE: begin
                    // restoring step: divisor pre-shifted by 6, one quotient bit per cycle
                    if (w_ge) r_rem <= r_rem - r_dvs;
                    r_dvs  <= r_dvs >> 1;
                    r_quo  <= {r_quo[5:0], w_ge};
                    r_step <= r_step + 3'd1;
                    if (r_step == 3'd6) begin
                        r_cov      <= {r_quo[5:0], w_ge};
                        r_finished <= r_finished || w_cov_hit || (r_useless >= c_ut_limit);
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_coverage_tracker.sv
`default_nettype none
// tb_coverage_tracker : random and directed tests against a set-based
// reference model, with a queue-driven result monitor.
module tb_coverage_tracker;
    localparam int NF  = 307;
    localparam int EF  = 1;
    localparam int UT  = 50;
    localparam int COV = 95;

    typedef struct {
        int ct;
        int keep;
        int at;
        int cov;
        int useless;
        int fin;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    exp_t sb[$];
    int   s_idx[$];
    bit   s_det[$];

    bit   m_at[int];
    int   m_at_cnt;
    int   m_useless;
    bit   m_fin;

    coverage_tracker_if bus();

    coverage_tracker #(
        .NUM_FAULTS (NF),
        .EF_COUNT   (EF),
        .UT_LIMIT   (UT),
        .DESIRED_COV(COV)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset && bus.result_valid) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_result: result_valid=1 expected 0 (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("latency", cyc, e.cyc);
                chk("ct_count", int'(bus.ct_count), e.ct);
                chk("keep", int'(bus.keep), e.keep);
                chk("at_count", int'(bus.at_count), e.at);
                chk("coverage_pct", int'(bus.coverage_pct), e.cov);
                chk("useless_cnt", int'(bus.useless_cnt), e.useless);
                chk("finished", int'(bus.finished), e.fin);
            end
        end
    end

    task automatic idle_inputs();
        bus.tv_start    = 1'b0;
        bus.tv_done     = 1'b0;
        bus.fault_valid = 1'b0;
        bus.fault_det   = 1'b0;
        bus.fault_idx   = 9'd0;
    endtask

    task automatic model_clear();
        m_at.delete();
        m_at_cnt  = 0;
        m_useless = 0;
        m_fin     = 1'b0;
        sb.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_result_valid"}, int'(bus.result_valid), 0);
        chk({tag, "_keep"}, int'(bus.keep), 0);
        chk({tag, "_ct_count"}, int'(bus.ct_count), 0);
        chk({tag, "_at_count"}, int'(bus.at_count), 0);
        chk({tag, "_coverage_pct"}, int'(bus.coverage_pct), 0);
        chk({tag, "_useless_cnt"}, int'(bus.useless_cnt), 0);
        chk({tag, "_finished"}, int'(bus.finished), 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        idle_inputs();
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL result_timeout: %0d results outstanding expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Faults before restart_at are discarded by a mid-test tv_start (-1: none).
    task automatic run_test(input bit lwd, input bit start_too, input int restart_at);
        int   nw[int];
        exp_t e;
        bit   expect_res;
        int   n;
        n = s_idx.size();
        expect_res = !m_fin;
        for (int i = 0; i < n; i++)
            if (i >= restart_at && s_det[i] && s_idx[i] >= 1 && s_idx[i] <= NF && !m_at.exists(s_idx[i]))
                nw[s_idx[i]] = 1;
        e.ct = nw.num();
        if (expect_res) begin
            if (e.ct >= EF) begin
                foreach (nw[k]) m_at[k] = 1'b1;
                m_at_cnt += e.ct;
                m_useless = 0;
                e.keep = 1;
            end else begin
                e.keep = 0;
                m_useless = (m_useless < 63) ? m_useless + 1 : 63;
            end
            m_fin = (m_at_cnt * 100 >= COV * NF) || (m_useless >= UT);
            e.at = m_at_cnt;
            e.cov = (m_at_cnt * 100) / NF;
            e.useless = m_useless;
            e.fin = int'(m_fin);
        end

        @(posedge clk); #1;
        bus.tv_start = 1'b1;
        @(posedge clk); #1;
        bus.tv_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i == restart_at) begin
                bus.fault_valid = 1'b0;
                bus.tv_start = 1'b1;
                @(posedge clk); #1;
                bus.tv_start = 1'b0;
            end
            bus.fault_valid = 1'b1;
            bus.fault_idx   = 9'(s_idx[i]);
            bus.fault_det   = s_det[i];
            if (i == n - 1 && lwd) break;
            @(posedge clk); #1;
        end
        if (!(lwd && n > 0)) bus.fault_valid = 1'b0;
        bus.tv_done  = 1'b1;
        bus.tv_start = start_too;
        e.cyc = cyc + 9;
        if (expect_res) sb.push_back(e);
        @(posedge clk); #1;
        idle_inputs();
        wait_drain();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int q[$];
        int j;
        int t;
        reset = 1'b0;
        idle_inputs();
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk_zero("rst");
        for (int i = 1; i <= NF; i++) begin
            bus.fault_idx = 9'(i);
            #1;
            chk("rst_fault_skip", int'(bus.fault_skip), 0);
        end
        bus.fault_idx = 9'd0;
        reset = 1'b1;
        @(posedge clk); #1;
        chk_zero("post_rst");

        s_idx = '{5, 5, 17};
        s_det = '{1, 1, 1};
        run_test(1'b0, 1'b0, -1);
        foreach (s_idx[i]) begin
            bus.fault_idx = 9'(s_idx[i]);
            #1;
            chk("skip_detected", int'(bus.fault_skip), 1);
        end
        q = '{0, 6, 400};
        foreach (q[i]) begin
            bus.fault_idx = 9'(q[i]);
            #1;
            chk("skip_not_detected", int'(bus.fault_skip), 0);
        end

        s_idx = '{5, 0, 400};
        s_det = '{1, 1, 1};
        run_test(1'b0, 1'b0, -1);

        for (int k = 0; k < 14; k++) begin
            s_idx.delete();
            s_det.delete();
            t = $urandom_range(0, 14);
            for (int i = 0; i < t; i++) begin
                s_idx.push_back($urandom_range(0, 330));
                s_det.push_back($urandom_range(0, 3) != 0);
            end
            j = ($urandom_range(0, 3) == 0 && t > 0) ? $urandom_range(0, t - 1) : -1;
            run_test(1'($urandom_range(0, 1)), 1'b0, j);
        end

        do_reset();
        q.delete();
        for (int i = 1; i <= 291; i++) q.push_back(i);
        for (int i = q.size() - 1; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = q[i];
            q[i] = q[j];
            q[j] = t;
        end
        s_idx.delete();
        s_det.delete();
        foreach (q[i]) begin
            s_idx.push_back(q[i]);
            s_det.push_back(1'b1);
            if (i % 50 == 0) begin
                s_idx.push_back(q[i]);
                s_det.push_back(1'b1);
            end
        end
        run_test(1'b0, 1'b0, -1);
        s_idx = '{300};
        s_det = '{1};
        run_test(1'b0, 1'b0, -1);
        s_idx = '{301};
        run_test(1'b0, 1'b0, -1);
        chk("ignored_start_at_count", int'(bus.at_count), 292);
        chk("ignored_start_busy", int'(bus.busy), 0);

        do_reset();
        for (int k = 0; k < 61; k++) begin
            s_idx.delete();
            s_det.delete();
            if (k == 10) begin
                s_idx.push_back(1);
                s_det.push_back(1'b1);
            end
            run_test(1'b0, 1'b0, -1);
        end
        chk("ut_finished", int'(bus.finished), 1);

        do_reset();
        @(posedge clk); #1;
        bus.tv_start = 1'b1;
        @(posedge clk); #1;
        bus.tv_start = 1'b0;
        bus.fault_valid = 1'b1;
        bus.fault_det = 1'b1;
        bus.fault_idx = 9'd3;
        @(posedge clk); #1;
        bus.fault_valid = 1'b0;
        bus.tv_done = 1'b1;
        @(posedge clk); #1;
        bus.tv_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_divide_busy", int'(bus.busy), 1);
        reset = 1'b0;
        #1;
        chk_zero("div_rst");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        bus.fault_idx = 9'd3;
        #1;
        chk("div_rst_skip", int'(bus.fault_skip), 0);
        bus.tv_done = 1'b1;
        @(posedge clk); #1;
        bus.tv_done = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("idle_done_busy", int'(bus.busy), 0);
        s_idx = '{7};
        s_det = '{1};
        run_test(1'b1, 1'b1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete, expected finish before 5ms");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
